// File: rtl/divapx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : divapx_pkg                                               |
// | Brief   : Shared types and defaults for seq_restoring_divider.     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package divapx_pkg;

   localparam int DW_DEFAULT         = 6;
   localparam int TRUNC_BITS_DEFAULT = 7;
   localparam int NW_DEFAULT         = 2 * DW_DEFAULT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : div_step_cell                                            |
// | Brief   : One combinational restoring-division step. Appends one   |
// |           dividend bit to the partial remainder and subtracts the  |
// |           divisor when that does not go negative.                  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module div_step_cell
   import divapx_pkg::*;
#(
   parameter int DW = DW_DEFAULT
)(
   input  logic [DW-1:0] prem,
   input  logic          in_bit,
   input  logic [DW-1:0] divisor,
   output logic [DW-1:0] next_prem,
   output logic          q_bit
);

   // Extra top bit acts as the borrow; the shifted remainder itself needs DW+1 bits.
   logic [DW+1:0] w_trial;
   logic [DW:0]   w_shifted;

   assign w_shifted = {prem, in_bit};
   assign w_trial   = {1'b0, w_shifted} - {2'b00, divisor};

   // Keep the difference when non-negative, otherwise restore the shifted remainder.
   always_comb begin
      q_bit     = ~w_trial[DW+1];
      next_prem = w_shifted[DW-1:0];
      if (!w_trial[DW+1]) begin
         next_prem = w_trial[DW-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : seq_restoring_divider                                    |
// | Brief   : Sequential unsigned restoring divider, 2*DW / DW -> DW   |
// |           quotient and remainder, one quotient bit per cycle,      |
// |           valid/ready on both sides.                               |
// |           Optional macro DIVAPX_TRUNC_EN zeroes the TRUNC_BITS     |
// |           dividend LSBs at capture (approximate-product format).   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module seq_restoring_divider
   import divapx_pkg::*;
#(
   parameter int DW         = DW_DEFAULT,
   parameter int TRUNC_BITS = TRUNC_BITS_DEFAULT
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*DW-1:0]   dividend,
   input  logic [DW-1:0]     divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     quotient,
   output logic [DW-1:0]     remainder,
   output logic              div_zero,
   output logic              ovf
);

   localparam int NW = 2 * DW;
   localparam int CW = $clog2(DW + 1);

`ifdef DIVAPX_TRUNC_EN
   localparam bit c_trunc_en = 1'b1;
`else
   localparam bit c_trunc_en = 1'b0;
`endif

   localparam logic [NW-1:0] c_trunc_mask =
      c_trunc_en ? ~((NW'(1) << TRUNC_BITS) - NW'(1)) : {NW{1'b1}};

   div_state_t    r_state;
   logic [DW-1:0] r_prem;
   logic [DW-1:0] r_shift;
   logic [DW-1:0] r_div;
   logic [CW-1:0] r_cnt;
   logic          r_in_ready;
   logic          r_out_valid;
   logic [DW-1:0] r_quot;
   logic [DW-1:0] r_rem;
   logic          r_div_zero;
   logic          r_ovf;

   logic [NW-1:0] w_eff;
   logic [DW-1:0] w_hi;
   logic [DW-1:0] w_lo;
   logic [DW-1:0] w_next_prem;
   logic          w_q_bit;

   assign w_eff = dividend & c_trunc_mask;
   assign w_hi  = w_eff[NW-1:DW];
   assign w_lo  = w_eff[DW-1:0];

   // The single step cell is reused every BUSY cycle; the dividend bit comes from the shift MSB.
   div_step_cell #(
      .DW        (DW)
   ) u_step (
      .prem      (r_prem),
      .in_bit    (r_shift[DW-1]),
      .divisor   (r_div),
      .next_prem (w_next_prem),
      .q_bit     (w_q_bit)
   );

   // Control FSM, iteration datapath and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_prem      <= '0;
         r_shift     <= '0;
         r_div       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_div_zero  <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_div_zero <= 1'b0;
                  r_ovf      <= 1'b0;
                  r_div      <= divisor;
                  if (divisor == '0) begin
                     r_div_zero <= 1'b1;
                     r_shift    <= '1;
                     r_prem     <= '0;
                     r_state    <= DONE;
                  end else if (w_hi >= divisor) begin
                     // Quotient would need more than DW bits.
                     r_ovf      <= 1'b1;
                     r_shift    <= '1;
                     r_prem     <= '0;
                     r_state    <= DONE;
                  end else begin
                     r_prem     <= w_hi;
                     r_shift    <= w_lo;
                     r_cnt      <= CW'(DW);
                     r_state    <= BUSY;
                  end
               end
            end
            BUSY: begin
               // Dividend bits leave at the MSB while quotient bits enter at the LSB.
               r_prem  <= w_next_prem;
               r_shift <= {r_shift[DW-2:0], w_q_bit};
               r_cnt   <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_quot      <= r_shift;
                  r_rem       <= r_prem;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign quotient  = r_quot;
   assign remainder = r_rem;
   assign div_zero  = r_div_zero;
   assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_seq_restoring_divider                                 |
// | Brief   : Directed table-driven bench for seq_restoring_divider    |
// |           (default build, truncation macro undefined).             |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_seq_restoring_divider;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] dividend;
   logic [5:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  quotient;
   logic [5:0]  remainder;
   logic        div_zero;
   logic        ovf;

   int total;
   int bad;

   typedef struct {
      logic [11:0] dvd;
      logic [5:0]  dvs;
      int          q;
      int          r;
      int          dz;
      int          ov;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   seq_restoring_divider u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Presents operands until accepted; returns at the negedge just after the accepting edge.
   task automatic accept(input logic [11:0] a, input logic [5:0] b);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("accept_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts edges after the accepting edge until out_valid is seen (bounded).
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("pop_valid_low", int'(out_valid), 0);
      check("pop_ready_high", int'(in_ready), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int a;
      int b;
      logic [5:0] q0;
      logic [5:0] r0;

      total = 0;
      bad   = 0;

      vecs[0]  = '{12'd595,  6'd17, 35, 0,  0, 0, 7};
      vecs[1]  = '{12'd600,  6'd17, 35, 5,  0, 0, 7};
      vecs[2]  = '{12'd100,  6'd0,  63, 0,  1, 0, 1};
      vecs[3]  = '{12'd4095, 6'd63, 63, 0,  0, 1, 1};
      vecs[4]  = '{12'd4031, 6'd63, 63, 62, 0, 0, 7};
      vecs[5]  = '{12'd10,   6'd3,  3,  1,  0, 0, 7};
      vecs[6]  = '{12'd0,    6'd5,  0,  0,  0, 0, 7};
      vecs[7]  = '{12'd4032, 6'd63, 63, 0,  0, 1, 1};
      vecs[8]  = '{12'd0,    6'd0,  63, 0,  1, 0, 1};
      vecs[9]  = '{12'd4095, 6'd0,  63, 0,  1, 0, 1};
      vecs[10] = '{12'd62,   6'd1,  62, 0,  0, 0, 7};
      vecs[11] = '{12'd63,   6'd1,  63, 0,  0, 0, 7};
      vecs[12] = '{12'd64,   6'd1,  63, 0,  0, 1, 1};
      vecs[13] = '{12'd1000, 6'd31, 32, 8,  0, 0, 7};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      // Reset state, sampled while reset is still asserted.
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_flags", int'({div_zero, ovf}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", int'(in_ready), 1);

      // Table-driven vectors.
      for (int i = 0; i < 14; i++) begin
         accept(vecs[i].dvd, vecs[i].dvs);
         wait_valid(lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_quotient", i), int'(quotient), vecs[i].q);
         check($sformatf("v%0d_remainder", i), int'(remainder), vecs[i].r);
         check($sformatf("v%0d_div_zero", i), int'(div_zero), vecs[i].dz);
         check($sformatf("v%0d_ovf", i), int'(ovf), vecs[i].ov);
         pop();
      end

      // Output stall with in_valid held high (with other operands) during BUSY/DONE.
      accept(12'd600, 6'd17);
      in_valid = 1'b1;
      dividend = 12'd4095;
      divisor  = 6'd0;
      wait_valid(lat);
      check("stall_latency", lat, 7);
      q0 = quotient;
      r0 = remainder;
      check("stall_q", int'(q0), 35);
      check("stall_r", int'(r0), 5);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("stall_valid", int'(out_valid), 1);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_q_hold", int'(quotient), 35);
         check("stall_r_hold", int'(remainder), 5);
         check("stall_flags", int'({div_zero, ovf}), 0);
      end
      in_valid = 1'b0;
      pop();

      // Reset on the third BUSY cycle aborts the divide.
      accept(12'd600, 6'd17);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_valid", int'(out_valid), 0);
      check("abort_q", int'(quotient), 0);
      check("abort_r", int'(remainder), 0);
      check("abort_in_ready", int'(in_ready), 0);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid) begin
            check("abort_spurious_valid", int'(out_valid), 0);
         end
      end
      accept(12'd10, 6'd3);
      wait_valid(lat);
      check("after_abort_latency", lat, 7);
      check("after_abort_q", int'(quotient), 3);
      check("after_abort_r", int'(remainder), 1);
      pop();

      // Random exact products a*b recover a with zero remainder.
      for (int n = 0; n < 100; n++) begin
         a = int'($urandom_range(63, 0));
         b = int'($urandom_range(63, 1));
         accept(12'(a * b), 6'(b));
         wait_valid(lat);
         check($sformatf("rnd_%0dx%0d_q", a, b), int'(quotient), a);
         check($sformatf("rnd_%0dx%0d_r", a, b), int'(remainder), 0);
         check($sformatf("rnd_%0dx%0d_flags", a, b), int'({div_zero, ovf}), 0);
         pop();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
